// File: rtl/mrv1_rf_pkg.sv
// Shared types and width helpers for the multi-threaded register file.
package mrv1_rf_pkg;

   typedef enum logic [1:0] {RF_INIT, RF_IDLE, RF_CLEAR} rf_state_e;

   function automatic int unsigned tid_width(input int unsigned num_tw);
      return (num_tw > 1) ? $clog2(num_tw) : 1;
   endfunction

   function automatic int unsigned flat_addr_width(input int unsigned num_tw,
                                                   input int unsigned addr_w);
      return tid_width(num_tw) + addr_w;
   endfunction

endpackage

// File: rtl/mrv1_rf_mp_if.sv
// Read/write/clear port bundle of mrv1_rf_mp; the register file is the slave side.
interface mrv1_rf_mp_if import mrv1_rf_pkg::*; #(
   parameter int unsigned DATA_WIDTH_P    = 32,
   parameter int unsigned NUM_TW_P        = 8,
   parameter int unsigned RF_ADDR_WIDTH_P = 5,
   parameter int unsigned NUM_RD_PORTS_P  = 2,
   parameter int unsigned NUM_WR_PORTS_P  = 2,
   localparam int unsigned TidW           = tid_width(NUM_TW_P)
) ();

   logic [NUM_RD_PORTS_P-1:0][TidW-1:0]            rs_tid_i;
   logic [NUM_RD_PORTS_P-1:0][RF_ADDR_WIDTH_P-1:0] rs_addr_i;
   logic [NUM_RD_PORTS_P-1:0][DATA_WIDTH_P-1:0]    rs_data_o;
   logic [NUM_WR_PORTS_P-1:0]                      rd_w_en_i;
   logic [NUM_WR_PORTS_P-1:0][TidW-1:0]            rd_tid_i;
   logic [NUM_WR_PORTS_P-1:0][RF_ADDR_WIDTH_P-1:0] rd_addr_i;
   logic [NUM_WR_PORTS_P-1:0][DATA_WIDTH_P-1:0]    rd_data_i;
   logic                                           clr_valid_i;
   logic [TidW-1:0]                                clr_tid_i;
   logic                                           clr_ready_o;
   logic                                           clr_done_o;
   logic                                           ready_o;

   modport master (
      output rs_tid_i, rs_addr_i, rd_w_en_i, rd_tid_i, rd_addr_i, rd_data_i,
             clr_valid_i, clr_tid_i,
      input  rs_data_o, clr_ready_o, clr_done_o, ready_o
   );

   modport slave (
      input  rs_tid_i, rs_addr_i, rd_w_en_i, rd_tid_i, rd_addr_i, rd_data_i,
             clr_valid_i, clr_tid_i,
      output rs_data_o, clr_ready_o, clr_done_o, ready_o
   );

endinterface

// File: rtl/mrv1_rf_sweep_ctrl.sv
// Init/clear sequencer: zeroes the whole array after reset and one thread on request.
module mrv1_rf_sweep_ctrl import mrv1_rf_pkg::*; #(
   parameter int unsigned NUM_TW_P        = 8,
   parameter int unsigned RF_ADDR_WIDTH_P = 5,
   localparam int unsigned TidW           = tid_width(NUM_TW_P),
   localparam int unsigned FlatW          = flat_addr_width(NUM_TW_P, RF_ADDR_WIDTH_P)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_valid_i,
   input  logic [TidW-1:0]  clr_tid_i,
   output logic             clr_ready_o,
   output logic             clr_done_o,
   output logic             ready_o,
   output logic             clearing_o,
   output logic [TidW-1:0]  clr_tid_o,
   output logic             sweep_we_o,
   output logic [FlatW-1:0] sweep_addr_o
);

   localparam logic [FlatW-1:0]           LastFlat = '1;
   localparam logic [RF_ADDR_WIDTH_P-1:0] LastIdx  = '1;

   rf_state_e         state_q, state_d;
   logic [FlatW-1:0]  cnt_q, cnt_d;
   logic [TidW-1:0]   clr_tid_q, clr_tid_d;
   logic              clr_done_q, clr_done_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= RF_INIT;
         cnt_q      <= '0;
         clr_tid_q  <= '0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_tid_q  <= clr_tid_d;
         clr_done_q <= clr_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clr_tid_d    = clr_tid_q;
      clr_done_d   = 1'b0;
      sweep_we_o   = 1'b0;
      sweep_addr_o = cnt_q;
      unique case (state_q)
         RF_INIT: begin
            sweep_we_o = 1'b1;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LastFlat) begin
               state_d = RF_IDLE;
               cnt_d   = '0;
            end
         end
         RF_IDLE: begin
            if (clr_valid_i) begin
               clr_tid_d = clr_tid_i;
               cnt_d     = '0;
               state_d   = RF_CLEAR;
            end
         end
         RF_CLEAR: begin
            // Only the index bits of the counter walk; the thread comes from the latch.
            sweep_we_o   = 1'b1;
            sweep_addr_o = {clr_tid_q, cnt_q[RF_ADDR_WIDTH_P-1:0]};
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q[RF_ADDR_WIDTH_P-1:0] == LastIdx) begin
               state_d    = RF_IDLE;
               clr_done_d = 1'b1;
               cnt_d      = '0;
            end
         end
         default: state_d = RF_INIT;
      endcase
   end

   assign ready_o     = (state_q != RF_INIT);
   assign clr_ready_o = (state_q == RF_IDLE);
   assign clearing_o  = (state_q == RF_CLEAR);
   assign clr_done_o  = clr_done_q;
   assign clr_tid_o   = clr_tid_q;

endmodule

// File: rtl/mrv1_rf_mp.sv
// Multi-threaded, multi-ported register file with init and per-thread clear sweeps.
// Define MRV1_RF_BYPASS_EN to forward same-cycle writes to matching reads.
module mrv1_rf_mp import mrv1_rf_pkg::*; #(
   parameter int unsigned DATA_WIDTH_P    = 32,
   parameter int unsigned NUM_TW_P        = 8,
   parameter int unsigned RF_ADDR_WIDTH_P = 5,
   parameter int unsigned NUM_RD_PORTS_P  = 2,
   parameter int unsigned NUM_WR_PORTS_P  = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   mrv1_rf_mp_if.slave  bus_io
);

   localparam int unsigned TidW  = tid_width(NUM_TW_P);
   localparam int unsigned FlatW = flat_addr_width(NUM_TW_P, RF_ADDR_WIDTH_P);
   localparam int unsigned Depth = 1 << FlatW;

   logic                                        ready;
   logic                                        clearing;
   logic [TidW-1:0]                             clr_tid;
   logic                                        sweep_we;
   logic [FlatW-1:0]                            sweep_addr;
   logic [NUM_WR_PORTS_P-1:0]                   wr_eff;
   logic [NUM_WR_PORTS_P-1:0][FlatW-1:0]        wr_flat;
   logic [NUM_RD_PORTS_P-1:0][FlatW-1:0]        rd_flat;
   logic [NUM_RD_PORTS_P-1:0][DATA_WIDTH_P-1:0] rd_data;
   logic [DATA_WIDTH_P-1:0]                     mem_q [Depth];

   mrv1_rf_sweep_ctrl #(
      .NUM_TW_P        (NUM_TW_P),
      .RF_ADDR_WIDTH_P (RF_ADDR_WIDTH_P)
   ) u_sweep_ctrl (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clr_valid_i  (bus_io.clr_valid_i),
      .clr_tid_i    (bus_io.clr_tid_i),
      .clr_ready_o  (bus_io.clr_ready_o),
      .clr_done_o   (bus_io.clr_done_o),
      .ready_o      (ready),
      .clearing_o   (clearing),
      .clr_tid_o    (clr_tid),
      .sweep_we_o   (sweep_we),
      .sweep_addr_o (sweep_addr)
   );

   assign bus_io.ready_o = ready;

   // A write counts only after init, to a non-zero index, and not into the thread being cleared.
   always_comb begin
      for (int w = 0; w < NUM_WR_PORTS_P; w++) begin
         wr_flat[w] = {bus_io.rd_tid_i[w], bus_io.rd_addr_i[w]};
         wr_eff[w]  = bus_io.rd_w_en_i[w] && ready && (bus_io.rd_addr_i[w] != '0) &&
                      !(clearing && (bus_io.rd_tid_i[w] == clr_tid));
      end
   end

   // Later ports overwrite earlier ones, so the highest-numbered port wins a collision.
   always_ff @(posedge clk_i) begin
      for (int w = 0; w < NUM_WR_PORTS_P; w++) begin
         if (wr_eff[w]) mem_q[wr_flat[w]] <= bus_io.rd_data_i[w];
      end
      if (sweep_we) mem_q[sweep_addr] <= '0;
   end

   always_comb begin
      for (int r = 0; r < NUM_RD_PORTS_P; r++) begin
         rd_flat[r] = {bus_io.rs_tid_i[r], bus_io.rs_addr_i[r]};
         rd_data[r] = mem_q[rd_flat[r]];
`ifdef MRV1_RF_BYPASS_EN
         for (int w = 0; w < NUM_WR_PORTS_P; w++) begin
            if (wr_eff[w] && (wr_flat[w] == rd_flat[r])) rd_data[r] = bus_io.rd_data_i[w];
         end
`endif
         if (!ready || (bus_io.rs_addr_i[r] == '0)) rd_data[r] = '0;
      end
   end

   assign bus_io.rs_data_o = rd_data;

endmodule

// File: tb/tb_mrv1_rf_mp.sv
// Self-checking bench for mrv1_rf_mp: vector table, hand sequences and random vs. a flat array model.
module tb_mrv1_rf_mp;

   logic clk;
   logic rst_ni;
   int   errors;
   int   checks;

   logic [31:0] model [256];

   typedef struct {
      logic        we0;
      logic [2:0]  wt0;
      logic [4:0]  wi0;
      logic [31:0] wd0;
      logic        we1;
      logic [2:0]  wt1;
      logic [4:0]  wi1;
      logic [31:0] wd1;
      logic [2:0]  rt0;
      logic [4:0]  ri0;
      logic [31:0] exp0;
      logic [2:0]  rt1;
      logic [4:0]  ri1;
      logic [31:0] exp1;
   } vec_t;

   vec_t vecs [5];

   mrv1_rf_mp_if #(
      .DATA_WIDTH_P    (32),
      .NUM_TW_P        (8),
      .RF_ADDR_WIDTH_P (5),
      .NUM_RD_PORTS_P  (2),
      .NUM_WR_PORTS_P  (2)
   ) bus ();

   mrv1_rf_mp #(
      .DATA_WIDTH_P    (32),
      .NUM_TW_P        (8),
      .RF_ADDR_WIDTH_P (5),
      .NUM_RD_PORTS_P  (2),
      .NUM_WR_PORTS_P  (2)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int flat(input logic [2:0] t, input logic [4:0] i);
      return int'(t) * 32 + int'(i);
   endfunction

   task automatic set_write(input int p, input logic en, input logic [2:0] t,
                            input logic [4:0] i, input logic [31:0] d);
      bus.rd_w_en_i[p] = en;
      bus.rd_tid_i[p]  = t;
      bus.rd_addr_i[p] = i;
      bus.rd_data_i[p] = d;
   endtask

   task automatic set_read(input int p, input logic [2:0] t, input logic [4:0] i);
      bus.rs_tid_i[p]  = t;
      bus.rs_addr_i[p] = i;
   endtask

   task automatic idle_inputs();
      bus.rd_w_en_i   = '0;
      bus.rd_tid_i    = '0;
      bus.rd_addr_i   = '0;
      bus.rd_data_i   = '0;
      bus.rs_tid_i    = '0;
      bus.rs_addr_i   = '0;
      bus.clr_valid_i = 1'b0;
      bus.clr_tid_i   = '0;
   endtask

   task automatic model_clear_all();
      for (int k = 0; k < 256; k++) model[k] = '0;
   endtask

   // Port 0 applied before port 1 so port 1 wins a same-entry collision.
   task automatic model_commit();
      for (int w = 0; w < 2; w++) begin
         if (bus.rd_w_en_i[w] && bus.rd_addr_i[w] != 0)
            model[flat(bus.rd_tid_i[w], bus.rd_addr_i[w])] = bus.rd_data_i[w];
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [2:0] t, input logic [4:0] i);
      logic [31:0] v;
      if (i == 0) return 32'h0;
      v = model[flat(t, i)];
`ifdef MRV1_RF_BYPASS_EN
      for (int w = 0; w < 2; w++) begin
         if (bus.rd_w_en_i[w] && bus.rd_addr_i[w] != 0 && bus.rd_tid_i[w] == t &&
             bus.rd_addr_i[w] == i)
            v = bus.rd_data_i[w];
      end
`endif
      return v;
   endfunction

   // Counts rising edges until ready_o, checking INIT-phase outputs and an ignored write.
   task automatic wait_ready(input string name);
      int n;
      bit bad;
      n   = 0;
      bad = 1'b0;
      set_read(0, 3'd3, 5'd7);
      set_read(1, 3'd0, 5'd5);
      while (bus.ready_o !== 1'b1 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         bus.rd_w_en_i = '0;
         if (n == 100) set_write(0, 1'b1, 3'd0, 5'd5, 32'h0000_1234);
         if (bus.ready_o !== 1'b1) begin
            if (bus.clr_ready_o !== 1'b0 || bus.rs_data_o[0] !== 32'h0 ||
                bus.rs_data_o[1] !== 32'h0)
               bad = 1'b1;
         end
         if (bus.clr_done_o !== 1'b0) bad = 1'b1;
      end
      bus.rd_w_en_i = '0;
      check({name, " init cycles"}, n, 256);
      check({name, " init outputs quiet"}, {31'h0, bad}, 32'h0);
      model_clear_all();
   endtask

   initial begin
      int n;
      bit bad;
      logic [2:0] rt [2];
      logic [4:0] ri [2];
      logic [31:0] exp_v;

      errors = 0;
      checks = 0;
      // {we0,t0,i0,d0, we1,t1,i1,d1, rt0,ri0,exp0, rt1,ri1,exp1}
      vecs[0] = '{1'b1, 3'd3, 5'd7, 32'hDEAD_BEEF, 1'b0, 3'd0, 5'd0, 32'h0,
                  3'd2, 5'd7, 32'h0, 3'd3, 5'd7, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 3'd1, 5'd4, 32'h0000_0011, 1'b1, 3'd1, 5'd4, 32'h0000_0022,
                  3'd1, 5'd4, 32'h0000_0022, 3'd3, 5'd7, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 3'd1, 5'd0, 32'h0000_00FF, 1'b1, 3'd2, 5'd0, 32'h0000_00EE,
                  3'd1, 5'd0, 32'h0, 3'd2, 5'd0, 32'h0};
      vecs[3] = '{1'b1, 3'd7, 5'd30, 32'h0000_0001, 1'b1, 3'd7, 5'd31, 32'hCAFE_0001,
                  3'd7, 5'd30, 32'h0000_0001, 3'd7, 5'd31, 32'hCAFE_0001};
      vecs[4] = '{1'b1, 3'd0, 5'd1, 32'h0000_0011, 1'b1, 3'd1, 5'd4, 32'h0000_0033,
                  3'd0, 5'd1, 32'h0000_0011, 3'd1, 5'd4, 32'h0000_0033};

      idle_inputs();
      model_clear_all();
      rst_ni = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ready_o", {31'h0, bus.ready_o}, 32'h0);
      check("reset clr_ready_o", {31'h0, bus.clr_ready_o}, 32'h0);
      check("reset clr_done_o", {31'h0, bus.clr_done_o}, 32'h0);
      check("reset rs_data_o", bus.rs_data_o[0], 32'h0);

      @(negedge clk);
      rst_ni = 1'b1;
      wait_ready("first");
      check("idle clr_ready_o", {31'h0, bus.clr_ready_o}, 32'h1);

      bad = 1'b0;
      for (int k = 0; k < 256; k++) begin
         set_read(0, 3'(k / 32), 5'(k % 32));
         set_read(1, 3'(7 - k / 32), 5'(31 - k % 32));
         #1;
         if (bus.rs_data_o[0] !== 32'h0 || bus.rs_data_o[1] !== 32'h0) bad = 1'b1;
      end
      check("post-init all reads zero", {31'h0, bad}, 32'h0);

      for (int v = 0; v < 5; v++) begin
         @(negedge clk);
         set_write(0, vecs[v].we0, vecs[v].wt0, vecs[v].wi0, vecs[v].wd0);
         set_write(1, vecs[v].we1, vecs[v].wt1, vecs[v].wi1, vecs[v].wd1);
         @(posedge clk);
         #1;
         model_commit();
         bus.rd_w_en_i = '0;
         set_read(0, vecs[v].rt0, vecs[v].ri0);
         set_read(1, vecs[v].rt1, vecs[v].ri1);
         #1;
         check($sformatf("vec%0d port0", v), bus.rs_data_o[0], vecs[v].exp0);
         check($sformatf("vec%0d port1", v), bus.rs_data_o[1], vecs[v].exp1);
      end

      // Same-cycle write/read of tid 0 idx 1 (old value 0x11).
      @(negedge clk);
      set_write(0, 1'b1, 3'd0, 5'd1, 32'h0000_00A5);
      set_read(0, 3'd0, 5'd1);
`ifdef MRV1_RF_BYPASS_EN
      exp_v = 32'h0000_00A5;
`else
      exp_v = 32'h0000_0011;
`endif
      #1;
      check("same-cycle rd/wr", bus.rs_data_o[0], exp_v);
      @(posedge clk);
      #1;
      model_commit();
      bus.rd_w_en_i = '0;
      #1;
      check("after rd/wr", bus.rs_data_o[0], 32'h0000_00A5);

      // Both ports hit tid 2 idx 3 while it is read.
      @(negedge clk);
      set_write(0, 1'b1, 3'd2, 5'd3, 32'h0000_0077);
      set_write(1, 1'b1, 3'd2, 5'd3, 32'h0000_0088);
      set_read(1, 3'd2, 5'd3);
`ifdef MRV1_RF_BYPASS_EN
      exp_v = 32'h0000_0088;
`else
      exp_v = 32'h0;
`endif
      #1;
      check("dual-write forward", bus.rs_data_o[1], exp_v);
      @(posedge clk);
      #1;
      model_commit();
      bus.rd_w_en_i = '0;

      for (int it = 0; it < 300; it++) begin
         @(negedge clk);
         for (int w = 0; w < 2; w++)
            set_write(w, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
                      5'($urandom_range(0, 7)), $urandom);
         for (int r = 0; r < 2; r++) begin
            rt[r] = 3'($urandom_range(0, 1));
            ri[r] = 5'($urandom_range(0, 7));
            set_read(r, rt[r], ri[r]);
         end
         #1;
         check($sformatf("rand%0d p0", it), bus.rs_data_o[0], ref_read(rt[0], ri[0]));
         check($sformatf("rand%0d p1", it), bus.rs_data_o[1], ref_read(rt[1], ri[1]));
         @(posedge clk);
         #1;
         model_commit();
      end
      @(negedge clk);
      bus.rd_w_en_i = '0;

      // Preload tid 5 and tid 4, then clear tid 5.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         set_write(0, 1'b1, 3'd5, 5'(i), 32'h5000_0000 | i);
         set_write(1, 1'b1, 3'd4, 5'(i), 32'h4000_0000 | i);
         @(posedge clk);
         #1;
         model_commit();
      end
      @(negedge clk);
      bus.rd_w_en_i   = '0;
      bus.clr_valid_i = 1'b1;
      bus.clr_tid_i   = 3'd5;
      #1;
      check("clear accept ready", {31'h0, bus.clr_ready_o}, 32'h1);
      @(posedge clk);
      #1;
      bus.clr_valid_i = 1'b0;
      check("clearing clr_ready_o", {31'h0, bus.clr_ready_o}, 32'h0);
      n   = 0;
      bad = 1'b0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         bus.rd_w_en_i = '0;
         if (bus.clr_done_o === 1'b1) break;
         if (bus.clr_ready_o !== 1'b0) bad = 1'b1;
         if (n == 5) begin
            set_read(0, 3'd5, 5'd20);
            set_read(1, 3'd5, 5'd2);
            #1;
            check("clearing read unswept", bus.rs_data_o[0], 32'h5000_0014);
            check("clearing read swept", bus.rs_data_o[1], 32'h0);
         end
         if (n == 15) begin
            set_write(0, 1'b1, 3'd5, 5'd9, 32'h0000_0005);
            set_write(1, 1'b1, 3'd6, 5'd9, 32'h0000_0006);
            set_read(0, 3'd5, 5'd9);
            set_read(1, 3'd6, 5'd9);
`ifdef MRV1_RF_BYPASS_EN
            exp_v = 32'h0000_0006;
`else
            exp_v = 32'h0;
`endif
            #1;
            check("clearing fwd dropped", bus.rs_data_o[0], 32'h0);
            check("clearing fwd other", bus.rs_data_o[1], exp_v);
         end
      end
      check("clr_done latency", n, 32);
      check("clearing quiet", {31'h0, bad}, 32'h0);
      @(posedge clk);
      #1;
      check("clr_done one cycle", {31'h0, bus.clr_done_o}, 32'h0);
      for (int i = 0; i < 32; i++) model[flat(3'd5, 5'(i))] = '0;
      model[flat(3'd6, 5'd9)] = 32'h0000_0006;

      bad = 1'b0;
      for (int t = 4; t < 7; t++) begin
         for (int i = 0; i < 32; i++) begin
            set_read(0, 3'(t), 5'(i));
            #1;
            if (bus.rs_data_o[0] !== ref_read(3'(t), 5'(i))) begin
               bad = 1'b1;
               $display("FAIL post-clear t%0d i%0d: got 0x%08h expected 0x%08h", t, i,
                        bus.rs_data_o[0], ref_read(3'(t), 5'(i)));
            end
         end
      end
      check("post-clear tids 4-6", {31'h0, bad}, 32'h0);

      // Reset in the middle of a clear.
      @(negedge clk);
      bus.clr_valid_i = 1'b1;
      bus.clr_tid_i   = 3'd2;
      @(posedge clk);
      #1;
      bus.clr_valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_ni = 1'b0;
      set_read(0, 3'd3, 5'd7);
      #1;
      check("mid-clear reset ready_o", {31'h0, bus.ready_o}, 32'h0);
      check("mid-clear reset clr_done_o", {31'h0, bus.clr_done_o}, 32'h0);
      check("mid-clear reset rs_data_o", bus.rs_data_o[0], 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;
      wait_ready("second");
      set_read(0, 3'd3, 5'd7);
      set_read(1, 3'd0, 5'd5);
      #1;
      check("reinit t3 i7", bus.rs_data_o[0], 32'h0);
      check("init write ignored", bus.rs_data_o[1], 32'h0);

      @(negedge clk);
      set_write(1, 1'b1, 3'd6, 5'd3, 32'h0000_600D);
      @(posedge clk);
      #1;
      bus.rd_w_en_i = '0;
      set_read(0, 3'd6, 5'd3);
      #1;
      check("write after reinit", bus.rs_data_o[0], 32'h0000_600D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mrv1_rf_mp.md
MRV1_RF_MP -- requirements
Module: mrv1_rf_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 32, meaning register data width.
REQ-002 SHALL have parameter NUM_TW_P, default 8, meaning hardware thread count (power of 2, at least 2).
REQ-003 SHALL have parameter RF_ADDR_WIDTH_P, default 5, meaning per-thread register index width.
REQ-004 SHALL have parameter NUM_RD_PORTS_P, default 2, meaning read port count (1..4).
REQ-005 SHALL have parameter NUM_WR_PORTS_P, default 2, meaning write port count (1..2).
REQ-006 SHALL have port clk_i, input, width 1, single clock, all state on rising edge.
REQ-007 SHALL have port rst_ni, input, width 1, asynchronous active-low reset.
REQ-008 SHALL have port rs_tid_i, input, NUM_RD_PORTS_P x tid width, per-read-port thread id.
REQ-009 SHALL have port rs_addr_i, input, NUM_RD_PORTS_P x RF_ADDR_WIDTH_P, read index.
REQ-010 SHALL have port rs_data_o, output, NUM_RD_PORTS_P x DATA_WIDTH_P, read data, combinational.
REQ-011 SHALL have ports rd_w_en_i, rd_tid_i, rd_addr_i and rd_data_i, input, NUM_WR_PORTS_P x (1, tid, RF_ADDR_WIDTH_P, DATA_WIDTH_P), write ports.
REQ-012 SHALL have ports clr_valid_i and clr_tid_i, input, widths 1 and tid, thread-clear request.
REQ-013 SHALL have port clr_ready_o, output, width 1, clear request accepted when valid and ready.
REQ-014 SHALL have port clr_done_o, output, width 1, one-cycle pulse at clear completion.
REQ-015 SHALL have port ready_o, output, width 1, high once the initial sweep completes.

Function
REQ-016 SHALL store NUM_TW_P x 2^RF_ADDR_WIDTH_P entries, addressed as the concatenation {tid, index}.
REQ-017 Reads of index 0 for any thread SHALL return 0; writes to index 0 SHALL be discarded.
REQ-018 States: INIT, IDLE and CLEAR.
REQ-019 INIT SHALL be entered on reset and SHALL write 0 to one flat entry per cycle, from 0 up to the last entry.
REQ-020 The INIT-to-IDLE transition SHALL follow the last-entry write; ready_o SHALL rise in the same cycle IDLE is entered.
REQ-021 In INIT, all writes SHALL be ignored, rs_data_o SHALL be 0, and clr_ready_o SHALL be 0.
REQ-022 clr_ready_o SHALL be 1 only in IDLE; an accepted clear SHALL latch clr_tid_i and enter CLEAR on the next cycle.
REQ-023 CLEAR SHALL zero entries 0 to 2^RF_ADDR_WIDTH_P-1 of the latched thread, one per cycle, taking exactly 2^RF_ADDR_WIDTH_P cycles.
REQ-024 After the CLEAR sweep, state SHALL return to IDLE with clr_done_o high for exactly one cycle.
REQ-025 During CLEAR, writes targeting the latched thread SHALL be dropped; writes to other threads SHALL proceed normally.
REQ-026 During CLEAR, reads SHALL return current stored contents.
REQ-027 Writes SHALL take effect at the clock edge; write latency is 1 cycle.
REQ-028 Same-cycle writes by two write ports to the same {tid, index} SHALL resolve with port NUM_WR_PORTS_P-1 winning.
REQ-029 A read and write to the same entry in the same cycle SHALL behave per REQ-034/035.

Reset
REQ-030 rst_ni low SHALL asynchronously force state INIT, sweep counter 0, ready_o 0, clr_ready_o 0, clr_done_o 0.
REQ-031 Storage array SHALL NOT be reset; it is initialised only by the INIT sweep.
REQ-032 Reset asserted mid-CLEAR SHALL abandon the clear without a clr_done_o pulse and restart the full INIT sweep.

Configuration
REQ-033 Macro MRV1_RF_BYPASS_EN SHALL select write-to-read forwarding.
REQ-034 With MRV1_RF_BYPASS_EN defined, a read matching a same-cycle effective write (after REQ-025/028 filtering, index not 0) SHALL return rd_data_i of the winning port.
REQ-035 Without MRV1_RF_BYPASS_EN, the same read SHALL return the pre-write stored value.

Structure
REQ-036 Package mrv1_rf_pkg SHALL hold enum rf_state_e {RF_INIT, RF_IDLE, RF_CLEAR} and the tid/flat-address width helper functions.
REQ-037 Sub-module mrv1_rf_sweep_ctrl SHALL hold the FSM, sweep counter and clear handshake, and SHALL output the sweep write enable and address to the array.

Verification
REQ-038 Bench SHALL check: release reset with defaults -> ready_o rises after exactly 256 cycles; every read returns 0.
REQ-039 Bench SHALL check: port0 writes tid 3 idx 7 = 0xDEADBEEF -> next cycle rs port1 (tid 3, idx 7) returns 0xDEADBEEF; tid 2 idx 7 returns 0.
REQ-040 Bench SHALL check: both write ports target tid 1 idx 4, with 0x11 and 0x22 -> stored 0x22; a write to idx 0 leaves reads at 0.
REQ-041 Bench SHALL check: clear tid 5 with entries preloaded -> clr_done_o pulses 32 cycles after entering CLEAR; tid 5 reads 0, tid 4 unchanged.
REQ-042 Bench SHALL check: during CLEAR of tid 5, write tid 5 idx 9 = 0x5 and tid 6 idx 9 = 0x6 -> tid 5 idx 9 reads 0 and tid 6 idx 9 reads 0x6.
REQ-043 Bench SHALL check: same-cycle write/read of tid 0 idx 1 = 0xA5 -> returns 0xA5 with MRV1_RF_BYPASS_EN, old value without; reset mid-CLEAR yields no clr_done_o and ready_o low for 256 cycles.
